// File: rtl/uart_tx_param_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param_if
// Description : Producer-side handshake and line signals of uart_tx_param.
//               The i_break member exists only when UART_TX_BREAK_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] i_data;
    logic                 i_valid;
    logic                 o_ready;
    logic                 o_txd;
    logic                 o_busy;
    logic                 o_done;

`ifdef UART_TX_BREAK_EN
    logic                 i_break;

    modport master (
        output i_data, i_valid, i_break,
        input  o_ready, o_txd, o_busy, o_done
    );
    modport slave (
        input  i_data, i_valid, i_break,
        output o_ready, o_txd, o_busy, o_done
    );
`else
    modport master (
        output i_data, i_valid,
        input  o_ready, o_txd, o_busy, o_done
    );
    modport slave (
        input  i_data, i_valid,
        output o_ready, o_txd, o_busy, o_done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param
// Description : Parametrised UART transmitter with built-in baud generator.
//               Accepts one word per valid/ready handshake and sends it LSB
//               first: start bit, DATA_BITS data bits, optional parity bit,
//               STOP_BITS stop bits. Each bit lasts CLK_FREQ/BAUD clocks.
//               Optional feature macro: UART_TX_BREAK_EN adds the i_break
//               input and a BREAK state that holds the line low.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  wire             i_clk,
    input  wire             i_reset_n,
    uart_tx_param_if.slave  bus
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(DIV - 1);
    localparam logic [2:0]       DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST  = 3'(STOP_BITS - 1);
    localparam bit               PARITY_ON  = (PARITY_MODE != 0);
    localparam logic             PARITY_ODD = (PARITY_MODE == 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] ST_BREAK  = 3'd5;
`endif

    logic [2:0]           state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity;
    logic                 txd;
    logic                 done;
    logic                 bit_end;

    // Last clock of the current bit period.
    assign bit_end = (baud_cnt == BAUD_LAST);

    // Baud counter: held at zero in IDLE so the start bit of every frame
    // gets a full DIV clocks from the accepting edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            baud_cnt <= '0;
        end else if (state == ST_IDLE || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

    // Frame sequencer: state, bit index, shift register and registered line.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            shift   <= '0;
            parity  <= 1'b0;
            txd     <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bit_cnt <= 3'd0;
`ifdef UART_TX_BREAK_EN
                    // Break request has priority over a pending word.
                    if (bus.i_break) begin
                        state <= ST_BREAK;
                        txd   <= 1'b0;
                    end else
`endif
                    if (bus.i_valid) begin
                        shift  <= bus.i_data;
                        parity <= (^bus.i_data) ^ PARITY_ODD;
                        txd    <= 1'b0;
                        state  <= ST_START;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        txd     <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= 3'd0;
                        state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= 3'd0;
                            if (PARITY_ON) begin
                                txd   <= parity;
                                state <= ST_PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (bit_end) begin
                        txd     <= 1'b1;
                        bit_cnt <= 3'd0;
                        state   <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= 3'd0;
                            done    <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

`ifdef UART_TX_BREAK_EN
                ST_BREAK: begin
                    if (!bus.i_break) begin
                        txd   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    txd   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready = (state == ST_IDLE);
    assign bus.o_busy  = (state != ST_IDLE);
    assign bus.o_txd   = txd;
    assign bus.o_done  = done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_param
// Description : Directed self-checking bench for uart_tx_param. Four
//               instances at DIV=10: 8N1, 8E1, 8O1 and 7N2. Break scenario
//               is included when UART_TX_BREAK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic cap_txd   [0:255];
    logic cap_busy  [0:255];
    logic cap_ready [0:255];
    logic cap_done  [0:255];

    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_BITS(8)) if0 ();
    uart_tx_param_if #(.DATA_BITS(8)) if1 ();
    uart_tx_param_if #(.DATA_BITS(8)) if2 ();
    uart_tx_param_if #(.DATA_BITS(7)) if3 ();

    uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8),
                    .PARITY_MODE(0), .STOP_BITS(1))
        dut0 (.i_clk(clk), .i_reset_n(rst_n), .bus(if0.slave));
    uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8),
                    .PARITY_MODE(2), .STOP_BITS(1))
        dut1 (.i_clk(clk), .i_reset_n(rst_n), .bus(if1.slave));
    uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8),
                    .PARITY_MODE(1), .STOP_BITS(1))
        dut2 (.i_clk(clk), .i_reset_n(rst_n), .bus(if2.slave));
    uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7),
                    .PARITY_MODE(0), .STOP_BITS(2))
        dut3 (.i_clk(clk), .i_reset_n(rst_n), .bus(if3.slave));

    // Drive the producer side of instance s.
    task automatic drive(input int s, input logic [7:0] d, input logic v);
        case (s)
            0:       begin if0.i_data = d;      if0.i_valid = v; end
            1:       begin if1.i_data = d;      if1.i_valid = v; end
            2:       begin if2.i_data = d;      if2.i_valid = v; end
            default: begin if3.i_data = d[6:0]; if3.i_valid = v; end
        endcase
    endtask

    // Record the outputs of instance s into slot j.
    task automatic sample(input int s, input int j);
        case (s)
            0:       begin cap_txd[j] = if0.o_txd; cap_busy[j] = if0.o_busy;
                           cap_ready[j] = if0.o_ready; cap_done[j] = if0.o_done; end
            1:       begin cap_txd[j] = if1.o_txd; cap_busy[j] = if1.o_busy;
                           cap_ready[j] = if1.o_ready; cap_done[j] = if1.o_done; end
            2:       begin cap_txd[j] = if2.o_txd; cap_busy[j] = if2.o_busy;
                           cap_ready[j] = if2.o_ready; cap_done[j] = if2.o_done; end
            default: begin cap_txd[j] = if3.o_txd; cap_busy[j] = if3.o_busy;
                           cap_ready[j] = if3.o_ready; cap_done[j] = if3.o_done; end
        endcase
    endtask

    // Offer word d; the next edge is the handshake edge k. Slot j holds the
    // outputs 1 time unit after edge k+j. Data switches to d2 after edge k+1
    // and valid drops after edge k+drop_at.
    task automatic send_capture(input int s, input logic [7:0] d, input logic [7:0] d2,
                                input int drop_at, input int ncyc);
        drive(s, d, 1'b1);
        @(posedge clk); #1;
        for (int j = 0; j < ncyc; j++) begin
            if (j == 1 && drop_at > 1) drive(s, d2, 1'b1);
            if (j == drop_at) drive(s, d2, 1'b0);
            sample(s, j);
            @(posedge clk); #1;
        end
        drive(s, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst_n = 1'b0;
        #23;
        for (int s = 0; s < 4; s++) begin
            sample(s, 0);
            got = {cap_txd[0], cap_ready[0], cap_busy[0], cap_done[0]};
            checks++;
            if (got !== 4'b1100) begin
                errors++;
                $display("FAIL reset_state dut%0d: got txd/ready/busy/done=%b expected 1100", s, got);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_8n1();
        logic [9:0] exp;
        logic [3:0] got, want;
        exp = 10'b1101001010;
        send_capture(0, 8'hA5, 8'hA5, 0, 103);
        for (int j = 0; j < 103; j++) begin
            want = {(j < 100) ? exp[j/DIV] : 1'b1, 1'(j < 100), 1'(j >= 100), 1'(j == 100)};
            got  = {cap_txd[j], cap_busy[j], cap_ready[j], cap_done[j]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL 8n1_a5 cycle %0d: got txd/busy/ready/done=%b expected %b", j, got, want);
            end
        end
    endtask

    task automatic test_even_parity();
        logic [10:0] exp;
        logic [3:0]  got, want;
        exp = 11'b10101001010;
        send_capture(1, 8'hA5, 8'hA5, 0, 113);
        for (int j = 0; j < 113; j++) begin
            want = {(j < 110) ? exp[j/DIV] : 1'b1, 1'(j < 110), 1'(j >= 110), 1'(j == 110)};
            got  = {cap_txd[j], cap_busy[j], cap_ready[j], cap_done[j]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL even_parity cycle %0d: got txd/busy/ready/done=%b expected %b", j, got, want);
            end
        end
    endtask

    task automatic test_odd_parity();
        logic [10:0] exp;
        logic [3:0]  got, want;
        exp = 11'b11101001010;
        send_capture(2, 8'hA5, 8'hA5, 0, 113);
        for (int j = 0; j < 113; j++) begin
            want = {(j < 110) ? exp[j/DIV] : 1'b1, 1'(j < 110), 1'(j >= 110), 1'(j == 110)};
            got  = {cap_txd[j], cap_busy[j], cap_ready[j], cap_done[j]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL odd_parity cycle %0d: got txd/busy/ready/done=%b expected %b", j, got, want);
            end
        end
    endtask

    // 0xC1 offered; only the low 7 bits (0x41) reach the 7-bit port.
    task automatic test_7d2s();
        logic [9:0] exp;
        logic [3:0] got, want;
        exp = 10'b1110000010;
        send_capture(3, 8'hC1, 8'hC1, 0, 103);
        for (int j = 0; j < 103; j++) begin
            want = {(j < 100) ? exp[j/DIV] : 1'b1, 1'(j < 100), 1'(j >= 100), 1'(j == 100)};
            got  = {cap_txd[j], cap_busy[j], cap_ready[j], cap_done[j]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL 7d2s_41 cycle %0d: got txd/busy/ready/done=%b expected %b", j, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp1, exp2;
        logic [3:0] got, want;
        exp1 = 10'b1010101010;
        exp2 = 10'b1101010100;
        send_capture(0, 8'h55, 8'hAA, 101, 204);
        for (int j = 0; j < 204; j++) begin
            if (j < 100)
                want = {exp1[j/DIV], 3'b100};
            else if (j == 100 || j == 201)
                want = 4'b1011;
            else if (j < 201)
                want = {exp2[(j-101)/DIV], 3'b100};
            else
                want = 4'b1010;
            got = {cap_txd[j], cap_busy[j], cap_ready[j], cap_done[j]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got txd/busy/ready/done=%b expected %b", j, got, want);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] exp;
        logic [3:0] got, want;
        // 0xF0: data bit 3 is 0, so the line is low when reset hits.
        drive(0, 8'hF0, 1'b1);
        @(posedge clk); #1;
        drive(0, 8'hF0, 1'b0);
        repeat (44) @(posedge clk);
        #1;
        checks++;
        if ({if0.o_txd, if0.o_busy} !== 2'b01) begin
            errors++;
            $display("FAIL midframe_bit3 got txd/busy=%b%b expected 01", if0.o_txd, if0.o_busy);
        end
        rst_n = 1'b0;
        #1;
        got = {if0.o_txd, if0.o_ready, if0.o_busy, if0.o_done};
        checks++;
        if (got !== 4'b1100) begin
            errors++;
            $display("FAIL async_reset got txd/ready/busy/done=%b expected 1100", got);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp = 10'b1101001010;
        send_capture(0, 8'hA5, 8'hA5, 0, 102);
        for (int j = 0; j < 102; j++) begin
            want = {(j < 100) ? exp[j/DIV] : 1'b1, 1'(j < 100), 1'(j >= 100), 1'(j == 100)};
            got  = {cap_txd[j], cap_busy[j], cap_ready[j], cap_done[j]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL after_reset cycle %0d: got txd/busy/ready/done=%b expected %b", j, got, want);
            end
        end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        logic [9:0] exp;
        logic [3:0] got, want;
        if0.i_break = 1'b1;
        drive(0, 8'h5A, 1'b1);
        for (int j = 0; j < 50; j++) begin
            @(posedge clk); #1;
            got = {if0.o_txd, if0.o_ready, if0.o_busy, if0.o_done};
            checks++;
            if (got !== 4'b0010) begin
                errors++;
                $display("FAIL break_hold cycle %0d: got txd/ready/busy/done=%b expected 0010", j, got);
            end
        end
        if0.i_break = 1'b0;
        @(posedge clk); #1;
        got = {if0.o_txd, if0.o_ready, if0.o_busy, if0.o_done};
        checks++;
        if (got !== 4'b1100) begin
            errors++;
            $display("FAIL break_exit got txd/ready/busy/done=%b expected 1100", got);
        end
        exp = 10'b1010110100;
        send_capture(0, 8'h5A, 8'h5A, 0, 102);
        for (int j = 0; j < 102; j++) begin
            want = {(j < 100) ? exp[j/DIV] : 1'b1, 1'(j < 100), 1'(j >= 100), 1'(j == 100)};
            got  = {cap_txd[j], cap_busy[j], cap_ready[j], cap_done[j]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL after_break cycle %0d: got txd/busy/ready/done=%b expected %b", j, got, want);
            end
        end
    endtask
`endif

    initial begin
        for (int s = 0; s < 4; s++) drive(s, 8'h00, 1'b0);
`ifdef UART_TX_BREAK_EN
        if0.i_break = 1'b0;
        if1.i_break = 1'b0;
        if2.i_break = 1'b0;
        if3.i_break = 1'b0;
`endif
        test_reset();
        test_8n1();
        test_even_parity();
        test_odd_parity();
        test_7d2s();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
